// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative cache controller: lookup, hit update, LRU victim choice,
// dirty write-back and refill. Drives the shared set index and all four RAM ports.
module cache_ctrl_2way #(
    parameter int INDEX_BIT          = 10,
    parameter int NUMBER_OF_SETS     = 1000,
    parameter int BLOCK_SIZE_WORDS   = 4,
    parameter int TOTAL_TAG_SIZE_BIT = 23
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic                            cpu_req_we,
    input  logic [21:0]                     cpu_req_addr,
    input  logic [31:0]                     cpu_req_wdata,
    output logic                            cpu_resp_valid,
    output logic [31:0]                     cpu_resp_rdata,
    output logic                            cpu_resp_hit,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_we,
    output logic [19:0]                     mem_req_addr,
    output logic [BLOCK_SIZE_WORDS*32-1:0]  mem_req_wdata,
    input  logic                            mem_resp_valid,
    input  logic [BLOCK_SIZE_WORDS*32-1:0]  mem_resp_rdata,
    output logic [INDEX_BIT-1:0]            ram_addr,
    output logic                            tag0_we,
    output logic                            tag1_we,
    output logic [TOTAL_TAG_SIZE_BIT-1:0]   tag0_wdata,
    output logic [TOTAL_TAG_SIZE_BIT-1:0]   tag1_wdata,
    input  logic [TOTAL_TAG_SIZE_BIT-1:0]   tag0_rdata,
    input  logic [TOTAL_TAG_SIZE_BIT-1:0]   tag1_rdata,
    output logic                            data0_we,
    output logic                            data1_we,
    output logic [BLOCK_SIZE_WORDS*32-1:0]  data0_wdata,
    output logic [BLOCK_SIZE_WORDS*32-1:0]  data1_wdata,
    input  logic [BLOCK_SIZE_WORDS*32-1:0]  data0_rdata,
    input  logic [BLOCK_SIZE_WORDS*32-1:0]  data1_rdata
);
    localparam int BLK_W = BLOCK_SIZE_WORDS * 32;
    localparam int TAG_W = TOTAL_TAG_SIZE_BIT;
    localparam int TV    = TAG_W - 1;
    localparam int TU    = TAG_W - 2;
    localparam int TD    = TAG_W - 3;

    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WB, REFILL, REFILL_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 we_q, we_d;
    logic [21:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [INDEX_BIT-1:0] set_q, set_d;
    logic [TAG_W-1:0]     tag0_q, tag0_d, tag1_q, tag1_d;
    logic                 victim_q, victim_d;
    logic                 mreq_valid_q, mreq_valid_d;
    logic                 mreq_we_q, mreq_we_d;
    logic [19:0]          mreq_addr_q, mreq_addr_d;
    logic [BLK_W-1:0]     mreq_wdata_q, mreq_wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic                 resp_hit_q, resp_hit_d;

    function automatic logic [31:0] get_word(input logic [BLK_W-1:0] blk, input logic [1:0] w);
        return blk[(BLOCK_SIZE_WORDS - 1 - int'(w)) * 32 +: 32];
    endfunction

    function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk, input logic [1:0] w,
                                                  input logic [31:0] d);
        logic [BLK_W-1:0] r;
        r = blk;
        r[(BLOCK_SIZE_WORDS - 1 - int'(w)) * 32 +: 32] = d;
        return r;
    endfunction

    logic             hit0, hit1, hit_way, victim;
    logic [TAG_W-1:0] hit_tag, oth_tag, hit_tag_new, oth_tag_new, vic_tag, fill_tag, keep_tag;
    logic [BLK_W-1:0] hit_data, vic_data, store_blk, fill_blk;
    logic [19:0]      blk_addr;
    logic [1:0]       word;

    assign blk_addr = addr_q[21:2];
    assign word     = addr_q[1:0];
    assign hit0     = tag0_rdata[TV] & (tag0_rdata[19:0] == blk_addr);
    assign hit1     = tag1_rdata[TV] & (tag1_rdata[19:0] == blk_addr);
    assign hit_way  = ~hit0;   // way 0 wins a (should-not-happen) double hit
    assign hit_tag  = hit_way ? tag1_rdata : tag0_rdata;
    assign oth_tag  = hit_way ? tag0_rdata : tag1_rdata;
    assign hit_data = hit_way ? data1_rdata : data0_rdata;
    assign hit_tag_new = {hit_tag[TV], 1'b1, hit_tag[TD] | we_q, hit_tag[TD-1:0]};
    assign oth_tag_new = {oth_tag[TV], 1'b0, oth_tag[TD:0]};
    assign store_blk   = put_word(hit_data, word, wdata_q);

    // Invalid way first (way 0 preferred), else the unused way, else way 0.
    assign victim   = tag0_rdata[TV] & (~tag1_rdata[TV] | (tag0_rdata[TU] & ~tag1_rdata[TU]));
    assign vic_tag  = victim ? tag1_rdata : tag0_rdata;
    assign vic_data = victim ? data1_rdata : data0_rdata;

    assign fill_tag = {1'b1, 1'b1, we_q, blk_addr};
    assign keep_tag = victim_q ? {tag0_q[TV], 1'b0, tag0_q[TD:0]} : {tag1_q[TV], 1'b0, tag1_q[TD:0]};
    assign fill_blk = we_q ? put_word(mem_resp_rdata, word, wdata_q) : mem_resp_rdata;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        set_d        = set_q;
        tag0_d       = tag0_q;
        tag1_d       = tag1_q;
        victim_d     = victim_q;
        mreq_valid_d = mreq_valid_q;
        mreq_we_d    = mreq_we_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_wdata_d = mreq_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        tag0_we      = 1'b0;
        tag1_we      = 1'b0;
        tag0_wdata   = '0;
        tag1_wdata   = '0;
        data0_we     = 1'b0;
        data1_we     = 1'b0;
        data0_wdata  = '0;
        data1_wdata  = '0;
        case (state_q)
            IDLE: if (cpu_req_valid) begin
                we_d    = cpu_req_we;
                addr_d  = cpu_req_addr;
                wdata_d = cpu_req_wdata;
                set_d   = INDEX_BIT'(32'(cpu_req_addr[21:2]) % NUMBER_OF_SETS);
                state_d = LOOKUP;
            end
            LOOKUP: state_d = COMPARE;
            COMPARE: begin
                tag0_d = tag0_rdata;
                tag1_d = tag1_rdata;
                if (hit0 | hit1) begin
                    tag0_we    = 1'b1;
                    tag1_we    = 1'b1;
                    tag0_wdata = hit_way ? oth_tag_new : hit_tag_new;
                    tag1_wdata = hit_way ? hit_tag_new : oth_tag_new;
                    data0_we   = we_q & ~hit_way;
                    data1_we   = we_q & hit_way;
                    data0_wdata = store_blk;
                    data1_wdata = store_blk;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_rdata_d = we_q ? 32'd0 : get_word(hit_data, word);
                    state_d      = IDLE;
                end else begin
                    victim_d     = victim;
                    mreq_valid_d = 1'b1;
                    if (vic_tag[TV] & vic_tag[TD]) begin
                        mreq_we_d    = 1'b1;
                        mreq_addr_d  = vic_tag[19:0];
                        mreq_wdata_d = vic_data;
                        state_d      = WB;
                    end else begin
                        mreq_we_d    = 1'b0;
                        mreq_addr_d  = blk_addr;
                        mreq_wdata_d = '0;
                        state_d      = REFILL;
                    end
                end
            end
            WB: if (mem_req_ready) begin
                mreq_we_d    = 1'b0;
                mreq_addr_d  = blk_addr;
                mreq_wdata_d = '0;
                state_d      = REFILL;
            end
            REFILL: if (mem_req_ready) begin
                mreq_valid_d = 1'b0;
                state_d      = REFILL_WAIT;
            end
            REFILL_WAIT: if (mem_resp_valid) begin
                tag0_we     = 1'b1;
                tag1_we     = 1'b1;
                tag0_wdata  = victim_q ? keep_tag : fill_tag;
                tag1_wdata  = victim_q ? fill_tag : keep_tag;
                data0_we    = ~victim_q;
                data1_we    = victim_q;
                data0_wdata = fill_blk;
                data1_wdata = fill_blk;
                resp_valid_d = 1'b1;
                resp_hit_d   = 1'b0;
                resp_rdata_d = we_q ? 32'd0 : get_word(mem_resp_rdata, word);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            set_q        <= '0;
            tag0_q       <= '0;
            tag1_q       <= '0;
            victim_q     <= 1'b0;
            mreq_valid_q <= 1'b0;
            mreq_we_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wdata_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            set_q        <= set_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            victim_q     <= victim_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_we_q    <= mreq_we_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_wdata_q <= mreq_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
        end
    end

    assign cpu_req_ready  = (state_q == IDLE);
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign mem_req_valid  = mreq_valid_q;
    assign mem_req_we     = mreq_we_q;
    assign mem_req_addr   = mreq_addr_q;
    assign mem_req_wdata  = mreq_wdata_q;
    assign ram_addr       = set_q;

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Bench for cache_ctrl_2way: behavioural tag/data RAMs, a main-memory responder,
// a table of single-request vectors and hand-written write-back / reset sequences.
module tb_cache_ctrl_2way;
    logic         clk, rst;
    logic         cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [21:0]  cpu_req_addr;
    logic [31:0]  cpu_req_wdata;
    logic         cpu_resp_valid, cpu_resp_hit;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_req_valid, mem_req_ready, mem_req_we;
    logic [19:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;
    logic [9:0]   ram_addr;
    logic         tag0_we, tag1_we, data0_we, data1_we;
    logic [22:0]  tag0_wdata, tag1_wdata, tag0_rdata, tag1_rdata;
    logic [127:0] data0_wdata, data1_wdata, data0_rdata, data1_rdata;

    cache_ctrl_2way dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .ram_addr(ram_addr),
        .tag0_we(tag0_we), .tag1_we(tag1_we), .tag0_wdata(tag0_wdata), .tag1_wdata(tag1_wdata),
        .tag0_rdata(tag0_rdata), .tag1_rdata(tag1_rdata),
        .data0_we(data0_we), .data1_we(data1_we), .data0_wdata(data0_wdata), .data1_wdata(data1_wdata),
        .data0_rdata(data0_rdata), .data1_rdata(data1_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] blk(input int b);
        return {32'(4*b), 32'(4*b+1), 32'(4*b+2), 32'(4*b+3)};
    endfunction

    function automatic logic [22:0] tg(input bit v, input bit u, input bit d, input int b);
        return {v, u, d, 20'(b)};
    endfunction

    // RAM models: registered read address, write on the rising edge.
    logic [22:0]  tag0_mem [1024];
    logic [22:0]  tag1_mem [1024];
    logic [127:0] data0_mem [1024];
    logic [127:0] data1_mem [1024];
    logic [9:0]   addr_r;
    bit           ram_inited;

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < 1024; i++) begin
                tag0_mem[i]  <= tg(1, 0, 0, i);
                tag1_mem[i]  <= tg(1, 0, 0, 1000 + i);
                data0_mem[i] <= blk(i);
                data1_mem[i] <= blk(1000 + i);
            end
            tag1_mem[2] <= '0;
            tag0_mem[6] <= tg(1, 0, 1, 6);
            tag1_mem[6] <= tg(1, 1, 0, 1006);
            ram_inited  <= 1'b1;
        end else begin
            if (tag0_we)  tag0_mem[ram_addr]  <= tag0_wdata;
            if (tag1_we)  tag1_mem[ram_addr]  <= tag1_wdata;
            if (data0_we) data0_mem[ram_addr] <= data0_wdata;
            if (data1_we) data1_mem[ram_addr] <= data1_wdata;
        end
        addr_r <= ram_addr;
    end
    assign tag0_rdata  = tag0_mem[addr_r];
    assign tag1_rdata  = tag1_mem[addr_r];
    assign data0_rdata = data0_mem[addr_r];
    assign data1_rdata = data1_mem[addr_r];

    int ram_wr_cnt, resp_cnt;
    always @(posedge clk) begin
        if (tag0_we | tag1_we | data0_we | data1_we) ram_wr_cnt++;
        if (cpu_resp_valid) resp_cnt++;
    end

    // Main memory: optional ready stall on a fresh request, configurable read latency.
    int           stall_cfg, resp_delay_cfg;
    int           wb_cnt, rd_cnt;
    logic [19:0]  rd_addr, last_wb_addr;
    logic [127:0] last_wb_data;
    logic [127:0] mmem [int];

    initial begin
        int st, rd_wait;
        bit rd_pending;
        st = 0; rd_wait = 0; rd_pending = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_req_ready  = 0;
            mem_resp_valid = 0;
            if (rd_pending) begin
                if (rd_wait > 0) rd_wait--;
                else begin
                    mem_resp_valid = 1;
                    mem_resp_rdata = mmem.exists(int'(rd_addr)) ? mmem[int'(rd_addr)] : blk(int'(rd_addr));
                    rd_pending = 0;
                end
            end else if (!mem_req_valid) begin
                st = stall_cfg;
            end else if (st > 0) begin
                st--;
            end else begin
                mem_req_ready = 1;
                if (mem_req_we) begin
                    wb_cnt++;
                    last_wb_addr = mem_req_addr;
                    last_wb_data = mem_req_wdata;
                    mmem[int'(mem_req_addr)] = mem_req_wdata;
                end else begin
                    rd_cnt++;
                    rd_addr    = mem_req_addr;
                    rd_pending = 1;
                    rd_wait    = resp_delay_cfg;
                end
            end
        end
    end

    int checks, errors;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [21:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!cpu_req_ready && n < 200) begin @(negedge clk); n++; end
        cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = d;
        @(posedge clk); #1;
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    endtask

    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic h, output bit ok);
        lat = 0; ok = 0; rd = '0; h = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_resp_valid) begin
                ok = 1; rd = cpu_resp_rdata; h = cpu_resp_hit;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        int          exp_lat;   // edges from accept to response; -1 = not checked
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, n;
        logic [31:0] rd;
        logic h;
        bit ok;
        logic [19:0] cap_addr;
        logic [127:0] cap_wdata;
        int wr0, rsp0;

        vecs[0] = '{1'b0, 22'd6,     32'd0,      32'd6,      1'b1, 2};
        vecs[1] = '{1'b0, 22'd4004,  32'd0,      32'd4004,   1'b1, 2};
        vecs[2] = '{1'b1, 22'd13,    32'h1234,   32'd0,      1'b1, 2};
        vecs[3] = '{1'b0, 22'd13,    32'd0,      32'h1234,   1'b1, 2};
        vecs[4] = '{1'b0, 22'd4015,  32'd0,      32'd4015,   1'b1, 2};
        vecs[5] = '{1'b0, 22'd8008,  32'd0,      32'd8008,   1'b0, -1};

        checks = 0; errors = 0;
        stall_cfg = 0; resp_delay_cfg = 2;
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        rst = 1;
        repeat (3) @(negedge clk);
        chk("reset ready", cpu_req_ready, 1);
        chk("reset resp_valid", cpu_resp_valid, 0);
        chk("reset mem_req_valid", mem_req_valid, 0);
        chk("reset mem_req_addr", mem_req_addr, 0);
        chk("reset ram_addr", ram_addr, 0);
        chk("reset ram we", {tag0_we, tag1_we, data0_we, data1_we}, 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            wait_resp(lat, rd, h, ok);
            chk($sformatf("vec%0d response seen", i), ok, 1);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d hit", i), h, vecs[i].exp_hit);
            if (vecs[i].exp_lat >= 0) chk($sformatf("vec%0d latency", i), lat - 1, vecs[i].exp_lat);
            if (i == 0) begin
                chk("set1 tag0 used after way0 hit", tag0_mem[1], tg(1, 1, 0, 1));
                chk("set1 tag1 used after way0 hit", tag1_mem[1], tg(1, 0, 0, 1001));
            end
        end
        chk("set1 tag0 after way1 hit", tag0_mem[1], tg(1, 0, 0, 1));
        chk("set1 tag1 after way1 hit", tag1_mem[1], tg(1, 1, 0, 1001));
        chk("set3 tag0 dirty kept", tag0_mem[3], tg(1, 0, 1, 3));
        chk("set3 tag1 used", tag1_mem[3], tg(1, 1, 0, 1003));
        chk("set3 data0 store merge", data0_mem[3], {32'd12, 32'h1234, 32'd14, 32'd15});
        chk("set2 refill addr", rd_addr, 20'd2002);
        chk("set2 no write-back", wb_cnt, 0);
        chk("set2 tag1 refilled", tag1_mem[2], tg(1, 1, 0, 2002));
        chk("set2 tag0 unchanged", tag0_mem[2], tg(1, 0, 0, 2));
        chk("set2 data1 refilled", data1_mem[2], blk(2002));

        // Store miss to set 6: dirty unused way 0 is written back under a 5-cycle ready stall.
        stall_cfg = 5;
        issue(1'b1, 22'd8025, 32'hDEAD);
        n = 0;
        while (!mem_req_valid && n < 50) begin @(negedge clk); n++; end
        chk("wb request raised", mem_req_valid, 1);
        chk("wb we", mem_req_we, 1);
        chk("wb addr", mem_req_addr, 20'd6);
        chk("wb wdata", mem_req_wdata, blk(6));
        cap_addr = mem_req_addr; cap_wdata = mem_req_wdata; wr0 = ram_wr_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk($sformatf("wb stall%0d valid", k), mem_req_valid, 1);
                chk($sformatf("wb stall%0d addr", k), mem_req_addr, cap_addr);
                chk($sformatf("wb stall%0d wdata", k), mem_req_wdata, cap_wdata);
            end
        end
        chk("no ram write during wb stall", ram_wr_cnt, wr0);
        stall_cfg = 0;
        wait_resp(lat, rd, h, ok);
        chk("store miss response seen", ok, 1);
        chk("store miss hit", h, 0);
        chk("store miss rdata", rd, 0);
        chk("wb count", wb_cnt, 1);
        chk("wb data at memory", last_wb_data, blk(6));
        chk("store miss refill addr", rd_addr, 20'd2006);
        chk("set6 tag0 new", tag0_mem[6], tg(1, 1, 1, 2006));
        chk("set6 tag1 used cleared", tag1_mem[6], tg(1, 0, 0, 1006));
        chk("set6 data0 merged", data0_mem[6], {32'd8024, 32'hDEAD, 32'd8026, 32'd8027});

        // Reset while waiting for refill data: the late response must be ignored.
        resp_delay_cfg = 20;
        n = rd_cnt;
        issue(1'b0, 22'd12016, 32'd0);
        lat = 0;
        while (rd_cnt == n && lat < 50) begin @(negedge clk); lat++; end
        chk("refill request accepted", rd_cnt, n + 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wr0 = ram_wr_cnt; rsp0 = resp_cnt;
        chk("mid reset ready", cpu_req_ready, 1);
        chk("mid reset mem_req_valid", mem_req_valid, 0);
        chk("mid reset resp_valid", cpu_resp_valid, 0);
        repeat (25) @(negedge clk);
        chk("no ram write after reset", ram_wr_cnt, wr0);
        chk("no response after reset", resp_cnt, rsp0);
        chk("set4 tag0 untouched", tag0_mem[4], tg(1, 0, 0, 4));
        chk("set4 tag1 untouched", tag1_mem[4], tg(1, 0, 0, 1004));
        resp_delay_cfg = 2;

        issue(1'b0, 22'd16, 32'd0);
        wait_resp(lat, rd, h, ok);
        chk("post reset hit", h, 1);
        chk("post reset rdata", rd, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
